timer_bank: RTL and testbench

//  Multi-channel programmable timer: CHANNELS independent counters share one prescaler.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_channel.sv | 105 ++++++++++
 rtl/timer_bank.sv | 76 +++++++
 tb/tb_timer_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer bank and its channels.
package timer_pkg;

    // Per-channel control state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Channel run mode, captured at start.
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, counter, shadowed final/compare/mode,
// registered done pulse and registered PWM level.
// Per-cycle priority is stop > start > tick; stop and start act even when
// the shared tick is frozen by the global enable.
// The FSM state is exposed on state_o so the parent (and any bound checker)
// can observe it directly.
module timer_channel
    import timer_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tick_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            mode_i,
    input  logic [BITS-1:0] final_value_i,
    input  logic [BITS-1:0] compare_i,
    output logic [BITS-1:0] count_o,
    output logic            done_o,
    output logic            pwm_o,
    output state_t          state_o
);

    state_t          state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] final_sh_q, final_sh_d;
    logic [BITS-1:0] cmp_sh_q, cmp_sh_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;
    logic            pwm_q, pwm_d;
    logic [BITS-1:0] count_inc;

    assign count_inc = count_q + 1'b1;

    // Register all channel state; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            count_q    <= '0;
            final_sh_q <= '0;
            cmp_sh_q   <= '0;
            mode_q     <= MODE_PERIODIC;
            done_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            final_sh_q <= final_sh_d;
            cmp_sh_q   <= cmp_sh_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            pwm_q      <= pwm_d;
        end
    end

    // Next-state logic: stop beats start, start beats tick. PWM is computed
    // from the count value that will be loaded, so it moves with count_o.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        final_sh_d = final_sh_q;
        cmp_sh_d   = cmp_sh_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        pwm_d      = pwm_q;

        if (stop_i) begin
            state_d = IDLE;
            count_d = '0;
            pwm_d   = 1'b0;
        end else if (start_i) begin
            final_sh_d = final_value_i;
            cmp_sh_d   = compare_i;
            mode_d     = mode_i;
            count_d    = '0;
            state_d    = RUN;
            pwm_d      = (compare_i != '0);
        end else if (state_q == RUN && tick_i) begin
            if (count_q == final_sh_q) begin
                done_d  = 1'b1;
                count_d = '0;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = IDLE;
                    pwm_d   = 1'b0;
                end else begin
                    // Periodic reload: new final/compare take effect here only.
                    final_sh_d = final_value_i;
                    cmp_sh_d   = compare_i;
                    pwm_d      = (compare_i != '0);
                end
            end else begin
                count_d = count_inc;
                pwm_d   = (count_inc < cmp_sh_q);
            end
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;
    assign pwm_o   = pwm_q;
    assign state_o = state_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: one shared prescaler produces a common
// tick that drives CHANNELS independent timer_channel instances.
//
// Handshake note: there is no valid/ready pairing here. start_i and stop_i
// are level requests sampled on every rising edge; holding one high repeats
// its action each cycle. done_o is a single-cycle pulse with no back-pressure.
module timer_bank
    import timer_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int CHANNELS      = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [PRESCALE_BITS-1:0] prescale_i,
    input  logic [CHANNELS-1:0]      start_i,
    input  logic [CHANNELS-1:0]      stop_i,
    input  logic [CHANNELS-1:0]      mode_i,
    input  logic [CHANNELS*BITS-1:0] final_value_i,
    input  logic [CHANNELS*BITS-1:0] compare_i,
    output logic [CHANNELS*BITS-1:0] count_o,
    output logic [CHANNELS-1:0]      busy_o,
    output logic [CHANNELS-1:0]      done_o,
    output logic [CHANNELS-1:0]      pwm_o
);

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic                     tick;

    // Using >= lets a divide value lowered on the fly wrap immediately
    // instead of rolling all the way round the counter.
    assign tick = enable_i && (presc_q >= prescale_i);

    // Prescaler next value: advance while enabled, wrap on tick, else hold.
    always_comb begin
        presc_d = presc_q;
        if (enable_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t ch_state;

        timer_channel #(
            .BITS (BITS)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .tick_i        (tick),
            .start_i       (start_i[g]),
            .stop_i        (stop_i[g]),
            .mode_i        (mode_i[g]),
            .final_value_i (final_value_i[g*BITS +: BITS]),
            .compare_i     (compare_i[g*BITS +: BITS]),
            .count_o       (count_o[g*BITS +: BITS]),
            .done_o        (done_o[g]),
            .pwm_o         (pwm_o[g]),
            .state_o       (ch_state)
        );

        assign busy_o[g] = (ch_state == RUN);
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (BITS=8, CHANNELS=4, PRESCALE_BITS=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_timer_bank;

  localparam int BITS = 8;
  localparam int CH   = 4;
  localparam int PB   = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_ni;
  logic               enable_i;
  logic [PB-1:0]      prescale_i;
  logic [CH-1:0]      start_i;
  logic [CH-1:0]      stop_i;
  logic [CH-1:0]      mode_i;
  logic [CH*BITS-1:0] final_value_i;
  logic [CH*BITS-1:0] compare_i;
  logic [CH*BITS-1:0] count_o;
  logic [CH-1:0]      busy_o;
  logic [CH-1:0]      done_o;
  logic [CH-1:0]      pwm_o;

  timer_bank #(.BITS(BITS), .CHANNELS(CH), .PRESCALE_BITS(PB)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .prescale_i    (prescale_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .mode_i        (mode_i),
    .final_value_i (final_value_i),
    .compare_i     (compare_i),
    .count_o       (count_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pwm_o         (pwm_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = '0;
    stop_i  = '0;
  endtask

  task automatic set_ch(input int n, input logic [7:0] fin, input logic [7:0] cmp, input logic mode);
    final_value_i[n*BITS +: BITS] = fin;
    compare_i[n*BITS +: BITS]     = cmp;
    mode_i[n]                     = mode;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  function automatic logic [7:0] cnt(input int n);
    return count_o[n*BITS +: BITS];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_ni        = 1'b0;
    enable_i      = 1'b0;
    prescale_i    = '0;
    start_i       = '0;
    stop_i        = '0;
    mode_i        = '0;
    final_value_i = '0;
    compare_i     = '0;

    // Reset state.
    do_reset();
    check("rst_count", count_o, 32'h0);
    check("rst_busy", {28'h0, busy_o}, 32'h0);
    check("rst_done", {28'h0, done_o}, 32'h0);
    check("rst_pwm", {28'h0, pwm_o}, 32'h0);

    // ---- Test 1: periodic ch0, final=3, compare=2, prescale 0 ----
    enable_i = 1'b1;
    prescale_i = 4'd0;
    set_ch(0, 8'd3, 8'd2, 1'b0);
    start_i = 4'b0001;
    step();
    idle_inputs();
    // {count, pwm, done} after each edge, starting with the start edge.
    exp_q = '{32'h010, 32'h110, 32'h200, 32'h300, 32'h011,
              32'h110, 32'h200, 32'h300, 32'h011};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      check($sformatf("t1_cyc%0d", i), {20'h0, cnt(0), 3'b0, pwm_o[0], 3'b0, done_o[0]}, exp_q.pop_front());
    end

    // ---- Test 2: one-shot ch1, final=1, prescale 2 ----
    do_reset();
    prescale_i = 4'd2;
    set_ch(1, 8'd1, 8'd1, 1'b1);
    enable_i = 1'b1;
    step();              // prescaler 0 -> 1
    step();              // prescaler 1 -> 2
    start_i = 4'b0010;   // start lands on a tick edge; prescaler wraps to 0
    step();
    idle_inputs();
    check("t2_busy_start", {31'h0, busy_o[1]}, 32'h1);
    check("t2_cnt_start", {24'h0, cnt(1)}, 32'h0);
    step(); step(); step();
    check("t2_cnt_after_tick", {24'h0, cnt(1)}, 32'h1);
    step(); step();
    check("t2_no_early_done", {31'h0, done_o[1]}, 32'h0);
    step();              // 6th edge after start: terminal tick
    check("t2_done", {31'h0, done_o[1]}, 32'h1);
    check("t2_busy_end", {31'h0, busy_o[1]}, 32'h0);
    check("t2_cnt_end", {24'h0, cnt(1)}, 32'h0);
    step();
    check("t2_done_one_cycle", {31'h0, done_o[1]}, 32'h0);

    // ---- Test 3: stop+start together, then freeze with enable low ----
    do_reset();
    prescale_i = 4'd0;
    enable_i = 1'b1;
    set_ch(0, 8'd5, 8'd4, 1'b0);
    start_i = 4'b0001;
    step();
    idle_inputs();
    step(); step(); step();
    check("t3_cnt3", {24'h0, cnt(0)}, 32'h3);
    stop_i  = 4'b0001;
    start_i = 4'b0001;
    step();
    idle_inputs();
    check("t3_stop_busy", {31'h0, busy_o[0]}, 32'h0);
    check("t3_stop_cnt", {24'h0, cnt(0)}, 32'h0);
    check("t3_stop_done", {31'h0, done_o[0]}, 32'h0);
    check("t3_stop_pwm", {31'h0, pwm_o[0]}, 32'h0);
    step();
    check("t3_stays_idle", {31'h0, busy_o[0]}, 32'h0);
    start_i = 4'b0001;
    step();
    idle_inputs();
    step();
    check("t3_run_cnt1", {24'h0, cnt(0)}, 32'h1);
    enable_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t3_frozen_cnt", {24'h0, cnt(0)}, 32'h1);
    check("t3_frozen_pwm", {31'h0, pwm_o[0]}, 32'h1);
    check("t3_frozen_busy", {31'h0, busy_o[0]}, 32'h1);
    enable_i = 1'b1;
    step();
    check("t3_resume_cnt", {24'h0, cnt(0)}, 32'h2);

    // ---- Test 4: reload only at period end; compare 0 and 7 ----
    do_reset();
    prescale_i = 4'd0;
    enable_i = 1'b1;
    set_ch(2, 8'd4, 8'd0, 1'b0);
    start_i = 4'b0100;
    step();
    idle_inputs();
    step();
    final_value_i[2*BITS +: BITS] = 8'd2;   // mid-period change
    // {count, pwm, done} for edges 2..10
    exp_q = '{32'h200, 32'h300, 32'h400, 32'h001,
              32'h100, 32'h200, 32'h001, 32'h100, 32'h200};
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("t4_cyc%0d", i), {20'h0, cnt(2), 3'b0, pwm_o[2], 3'b0, done_o[2]}, exp_q.pop_front());
    end
    compare_i[2*BITS +: BITS] = 8'd7;
    start_i = 4'b0100;
    step();
    idle_inputs();
    exp_q = '{32'h010, 32'h110, 32'h210, 32'h011};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check($sformatf("t4_hi%0d", i), {20'h0, cnt(2), 3'b0, pwm_o[2], 3'b0, done_o[2]}, exp_q.pop_front());
    end

    // ---- Test 5: four channels, restart ch2, reset mid-run ----
    do_reset();
    prescale_i = 4'd0;
    enable_i = 1'b1;
    set_ch(0, 8'd0,   8'd1, 1'b0);
    set_ch(1, 8'd1,   8'd1, 1'b0);
    set_ch(2, 8'd2,   8'd1, 1'b0);
    set_ch(3, 8'd255, 8'd1, 1'b0);
    start_i = 4'b1111;
    step();
    idle_inputs();
    check("t5_busy", {28'h0, busy_o}, 32'hF);
    check("t5_cnt_e0", count_o, 32'h0);
    step();
    check("t5_done_e1", {28'h0, done_o}, 32'h1);
    step();
    check("t5_done_e2", {28'h0, done_o}, 32'h3);
    check("t5_cnt_e2", count_o, 32'h02020000);
    start_i = 4'b0100;   // restart ch2 on what would be its terminal edge
    step();
    idle_inputs();
    check("t5_done_e3", {28'h0, done_o}, 32'h1);
    check("t5_cnt_e3", count_o, 32'h03000100);
    check("t5_pwm_e3", {28'h0, pwm_o}, 32'h5);
    step();
    check("t5_done_e4", {28'h0, done_o}, 32'h3);
    check("t5_cnt_e4", count_o, 32'h04010000);
    check("t5_pwm_e4", {28'h0, pwm_o}, 32'h3);
    rst_ni = 1'b0;
    step();
    check("t5_rst_cnt", count_o, 32'h0);
    check("t5_rst_busy", {28'h0, busy_o}, 32'h0);
    check("t5_rst_done", {28'h0, done_o}, 32'h0);
    check("t5_rst_pwm", {28'h0, pwm_o}, 32'h0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
